// File: rtl/i2s_tx_sequencer.sv
// Playback sequencer for the PCM-to-I2S output stage: flush, pre-fill, run,
// underrun re-prime and graceful drain, driving the converter's audio_en/audio_test.
module i2s_tx_sequencer #(
  parameter int FLUSH_CYCLES     = 16,
  parameter int PREFILL_TIMEOUT  = 4194304,
  parameter int UNDERRUN_FRAMES  = 2,
  parameter int DRAIN_MAX_FRAMES = 512,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             play_req,
  input  logic             test_req,
  input  logic             clr_stats,
  input  logic             lrclk,
  input  logic             l_fifo_empty,
  input  logic             r_fifo_empty,
  input  logic             r_half_full,
  output logic             audio_en,
  output logic             audio_test,
  output logic [2:0]       state,
  output logic             running,
  output logic             underrun_irq,
  output logic [CNT_W-1:0] underrun_count,
  output logic             fault
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    PREFILL = 3'd2,
    RUN     = 3'd3,
    DRAIN   = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [22:0]      FLUSH_LAST    = 23'(FLUSH_CYCLES - 1);
  localparam logic [22:0]      PREFILL_LAST  = 23'(PREFILL_TIMEOUT - 1);
  localparam logic [9:0]       UNDERRUN_LAST = 10'(UNDERRUN_FRAMES - 1);
  localparam logic [9:0]       DRAIN_LAST    = 10'(DRAIN_MAX_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;

  state_t      st;
  state_t      nxt;
  logic [22:0] clk_cnt;
  logic [9:0]  frame_cnt;
  logic        lrclk_q;
  logic        tick;
  logic        any_empty;
  logic        both_empty;
  logic        ur_hit;
  logic        to_fault;

  assign tick       = lrclk & ~lrclk_q;
  assign any_empty  = l_fifo_empty | r_fifo_empty;
  assign both_empty = l_fifo_empty & r_fifo_empty;
  assign state      = st;

  // Dropping play_req outranks every other exit in each state.
  always_comb begin
    nxt      = st;
    ur_hit   = 1'b0;
    to_fault = 1'b0;
    case (st)
      IDLE:    if (play_req) nxt = FLUSH;
      FLUSH: begin
        if (!play_req)                  nxt = IDLE;
        else if (clk_cnt == FLUSH_LAST) nxt = PREFILL;
      end
      PREFILL: begin
        if (!play_req)         nxt = IDLE;
        else if (r_half_full)  nxt = RUN;
        else if (clk_cnt == PREFILL_LAST) begin
          nxt      = FAULT;
          to_fault = 1'b1;
        end
      end
      RUN: begin
        if (!play_req) nxt = DRAIN;
        else if (tick && any_empty && frame_cnt == UNDERRUN_LAST) begin
          nxt    = FLUSH;
          ur_hit = 1'b1;
        end
      end
      DRAIN:   if (tick && (both_empty || frame_cnt == DRAIN_LAST)) nxt = IDLE;
      FAULT:   if (!play_req) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st             <= IDLE;
      clk_cnt        <= '0;
      frame_cnt      <= '0;
      lrclk_q        <= 1'b0;
      audio_en       <= 1'b0;
      audio_test     <= 1'b0;
      running        <= 1'b0;
      underrun_irq   <= 1'b0;
      underrun_count <= '0;
      fault          <= 1'b0;
    end else begin
      st      <= nxt;
      lrclk_q <= lrclk;
      if (nxt != st) begin
        clk_cnt   <= '0;
        frame_cnt <= '0;
      end else begin
        if (st == FLUSH || st == PREFILL) clk_cnt <= clk_cnt + 23'd1;
        if (tick && st == RUN)   frame_cnt <= any_empty ? frame_cnt + 10'd1 : 10'd0;
        if (tick && st == DRAIN) frame_cnt <= frame_cnt + 10'd1;
      end
      audio_en     <= (nxt == PREFILL) || (nxt == RUN) || (nxt == DRAIN);
      audio_test   <= (nxt == RUN) && test_req;
      running      <= (nxt == RUN);
      underrun_irq <= ur_hit;
      // A clear coinciding with an underrun leaves that underrun counted.
      if (clr_stats)
        underrun_count <= ur_hit ? CNT_W'(1) : '0;
      else if (ur_hit && underrun_count != CNT_MAX)
        underrun_count <= underrun_count + CNT_W'(1);
      if (clr_stats)     fault <= 1'b0;
      else if (to_fault) fault <= 1'b1;
    end
  end

endmodule

// File: doc/i2s_tx_sequencer.md
Name: i2s_tx_sequencer

Overview:
Playback controller for the PCM-to-I2S output stage. It owns the converter's audio_en and audio_test inputs and sequences playback through these steps:
- flush the L/R sample FIFOs by holding audio_en low;
- pre-fill until the right FIFO reaches its programmable threshold;
- run;
- detect underrun and re-prime automatically;
- drain gracefully on stop.
It sits between the host control registers and the converter, and reports status and an underrun count.

Parameters:
FLUSH_CYCLES, 16, clk cycles audio_en is held low in FLUSH (FIFO reset width)
PREFILL_TIMEOUT, 4194304, clk cycles allowed in PREFILL before FAULT (~85 ms at 49.152 MHz)
UNDERRUN_FRAMES, 2, consecutive frames with an empty FIFO that declare an underrun
DRAIN_MAX_FRAMES, 512, maximum frames spent in DRAIN
CNT_W, 16, width of underrun_count

Ports:
clk  in  1  49.152 MHz system clock
reset_n  in  1  asynchronous active-low reset
play_req  in  1  level; 1 = host requests playback
test_req  in  1  level; 1 = substitute test pattern while running
clr_stats  in  1  pulse; clears underrun_count and fault
lrclk  in  1  frame clock from converter, synchronous to clk
l_fifo_empty  in  1  left sample FIFO empty
r_fifo_empty  in  1  right sample FIFO empty
r_half_full  in  1  right FIFO prog_full (pre-fill threshold reached)
audio_en  out  1  converter enable; 0 also resets converter FIFOs
audio_test  out  1  converter test-pattern select
state  out  3  current state encoding
running  out  1  1 when state == RUN
underrun_irq  out  1  one-cycle pulse per declared underrun
underrun_count  out  CNT_W  saturating underrun counter
fault  out  1  sticky; set on pre-fill timeout

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE; audio_en=0, audio_test=0, running=0, underrun_irq=0, underrun_count=0, fault=0.
  - All internal counters and the lrclk delay register cleared.
- All outputs are registered. A state change is visible one clk after the qualifying input edge.
- Frame tick = lrclk rising edge, detected against a registered copy of lrclk (tick asserts the cycle lrclk=1 and lrclk_q=0).
- State encoding: IDLE=0, FLUSH=1, PREFILL=2, RUN=3, DRAIN=4, FAULT=5.
- IDLE: audio_en=0. play_req=1 -> FLUSH.
- FLUSH:
  - audio_en=0; count FLUSH_CYCLES clks, then -> PREFILL.
  - play_req=0 during FLUSH -> IDLE immediately.
- PREFILL:
  - audio_en=1; clk counter runs.
  - r_half_full=1 -> RUN.
  - Counter reaching PREFILL_TIMEOUT -> FAULT and set fault.
  - play_req=0 -> IDLE; this has priority over both r_half_full and timeout in the same cycle.
- RUN:
  - audio_en=1; audio_test=test_req, registered. audio_test is forced to 0 in every other state.
  - On each frame tick:
    - if l_fifo_empty or r_fifo_empty, increment the consecutive-empty counter, else clear it.
    - When the counter reaches UNDERRUN_FRAMES: pulse underrun_irq for 1 clk, increment underrun_count (saturating at all-ones), clear the counter, -> FLUSH.
  - play_req=0 -> DRAIN; this has priority over an underrun in the same cycle (no irq, no increment).
- DRAIN:
  - audio_en=1; counts frame ticks.
  - -> IDLE on the first frame tick with both FIFOs empty, or when the count reaches DRAIN_MAX_FRAMES.
  - play_req is ignored in DRAIN. If play_req is still high on return to IDLE, IDLE -> FLUSH on the next clk.
- FAULT: audio_en=0. Stays in FAULT until play_req=0, then -> IDLE. fault remains set.
- clr_stats:
  - Clears underrun_count and fault in any state.
  - Same cycle as an underrun increment -> underrun_count=1 and underrun_irq still pulses.
  - Does not change state.
- Counters: the FLUSH/PREFILL clk counter is 23 bits, the frame counter 10 bits. Each is cleared on every state entry. No wrap-around is possible because every terminal value exits the state.
- Invariant: audio_en is never 1 in IDLE, FLUSH or FAULT.

Test Plan:
- Reset release, play_req=1, r_half_full asserted 40 clks after PREFILL entry -> audio_en 0 for exactly 16 clks, state IDLE→FLUSH→PREFILL→RUN, running=1.
- In RUN, force r_fifo_empty=1 across 2 frame ticks -> single underrun_irq pulse, underrun_count 0→1, state→FLUSH, audio_en=0 for 16 clks, then re-prime.
- Empty FIFO on 1 tick then not empty on the next, repeated 10 times -> no underrun; underrun_count stays 0.
- PREFILL with r_half_full held 0 and PREFILL_TIMEOUT overridden to 100 -> FAULT after 100 clks, fault=1, audio_en=0; drop play_req -> IDLE; clr_stats -> fault=0.
- In RUN, drop play_req with FIFOs non-empty, then both empty at the 3rd frame tick -> DRAIN for 3 ticks, then IDLE with audio_en=0. Repeat with FIFOs never empty and DRAIN_MAX_FRAMES=4 -> IDLE after 4 ticks.
- Underrun tick coincident with play_req falling -> state DRAIN, no irq, count unchanged. Then force underrun_count=0xFFFF plus an underrun -> count stays 0xFFFF and irq pulses. Assert reset_n mid-RUN -> all outputs at reset values asynchronously.
